// File: rtl/gobang_move_ctrl.sv
// Move controller for the 15x15 gobang board.
// Owns both stone maps, checks each offered move for legality, writes legal
// stones, hands the last move to the win checkers for one cycle, and turns
// their combined verdict into win / draw / next turn.
module gobang_move_ctrl #(
  parameter int unsigned BOARD_N      = 15,
  parameter int unsigned CELLS        = BOARD_N * BOARD_N,
  parameter bit          FIRST_PLAYER = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             move_valid,
  input  logic [3:0]       move_row,
  input  logic [3:0]       move_col,
  output logic             move_ready,
  output logic             move_reject,
  output logic [3:0]       chk_row,
  output logic [3:0]       chk_col,
  output logic [CELLS-1:0] chk_map,
  output logic             chk_req,
  input  logic             win_in,
  output logic [CELLS-1:0] black_map,
  output logic [CELLS-1:0] white_map,
  output logic             turn,
  output logic [7:0]       move_count,
  output logic             game_over,
  output logic [1:0]       winner
);

  // Wide enough for row = col = 15 (out-of-range requests) without truncation.
  localparam int unsigned IDX_W    = $clog2(15 * (BOARD_N + 1) + 1);
  localparam logic [3:0]  MAX_RC   = 4'(BOARD_N - 1);
  localparam logic [7:0]  FULL_CNT = 8'(CELLS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHECK    = 2'd1,
    S_GAMEOVER = 2'd2
  } state_t;

  state_t           r_state;
  logic [CELLS-1:0] r_black_map;
  logic [CELLS-1:0] r_white_map;
  logic [3:0]       r_chk_row;
  logic [3:0]       r_chk_col;
  logic             r_chk_req;
  logic             r_move_ready;
  logic             r_move_reject;
  logic             r_turn;
  logic [7:0]       r_move_count;
  logic             r_game_over;
  logic [1:0]       r_winner;

  logic [IDX_W-1:0] w_idx;
  logic [CELLS-1:0] w_onehot;
  logic             w_in_range;
  logic             w_occupied;
  logic             w_legal;

  // Cell index and legality of the request currently on the move port.
  // An out-of-range index shifts the one-hot to zero, so the occupancy test
  // never reads past the map; the range test rejects such moves anyway.
  always_comb begin
    w_idx      = IDX_W'(move_row) * IDX_W'(BOARD_N) + IDX_W'(move_col);
    w_onehot   = {{(CELLS-1){1'b0}}, 1'b1} << w_idx;
    w_in_range = (move_row <= MAX_RC) && (move_col <= MAX_RC);
    w_occupied = |((r_black_map | r_white_map) & w_onehot);
    w_legal    = w_in_range && !w_occupied;
  end

  // Game FSM: move intake in IDLE, one-cycle verdict in CHECK, frozen in GAMEOVER.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_state       <= S_IDLE;
      r_black_map   <= '0;
      r_white_map   <= '0;
      r_chk_row     <= '0;
      r_chk_col     <= '0;
      r_chk_req     <= 1'b0;
      r_move_ready  <= 1'b1;
      r_move_reject <= 1'b0;
      r_turn        <= FIRST_PLAYER;
      r_move_count  <= '0;
      r_game_over   <= 1'b0;
      r_winner      <= 2'b00;
    end else begin
      r_move_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (move_valid) begin
            if (w_legal) begin
              if (r_turn) r_white_map <= r_white_map | w_onehot;
              else        r_black_map <= r_black_map | w_onehot;
              r_chk_row    <= move_row;
              r_chk_col    <= move_col;
              r_move_count <= r_move_count + 8'd1;
              r_chk_req    <= 1'b1;
              r_move_ready <= 1'b0;
              r_state      <= S_CHECK;
            end else begin
              r_move_reject <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          r_chk_req <= 1'b0;
          if (win_in) begin
            r_winner    <= r_turn ? 2'b10 : 2'b01;
            r_game_over <= 1'b1;
            r_state     <= S_GAMEOVER;
          end else if (r_move_count == FULL_CNT) begin
            r_winner    <= 2'b11;
            r_game_over <= 1'b1;
            r_state     <= S_GAMEOVER;
          end else begin
            r_turn       <= ~r_turn;
            r_move_ready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_GAMEOVER: begin
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // During CHECK the turn has not toggled yet, so this selects the mover's map.
  always_comb begin
    chk_map = r_turn ? r_white_map : r_black_map;
  end

  assign move_ready  = r_move_ready;
  assign move_reject = r_move_reject;
  assign chk_row     = r_chk_row;
  assign chk_col     = r_chk_col;
  assign chk_req     = r_chk_req;
  assign black_map   = r_black_map;
  assign white_map   = r_white_map;
  assign turn        = r_turn;
  assign move_count  = r_move_count;
  assign game_over   = r_game_over;
  assign winner      = r_winner;

endmodule
